// File: rtl/cordic_hyperbolic_par.sv
// Iterative hyperbolic CORDIC: one micro-rotation per clock, rotation (sinh/cosh)
// or vectoring (atanh/magnitude) mode, with the mandatory repeats of indices 4 and 13.
module cordic_hyperbolic_par #(
  parameter int W    = 16,
  parameter int FRAC = 12,
  parameter int ITER = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic [W-1:0] z_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W-1:0] z_out
);

  localparam int STEPS = ITER + ((ITER >= 4) ? 1 : 0) + ((ITER >= 13) ? 1 : 0);
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // atanh(2^-i) in Q2.30; beyond i=10 the cubic term is below half an LSB.
  function automatic longint atanh_q30(input int i);
    longint v;
    v = 64'sd0;
    case (i)
      1:  v = 64'sd589812981;
      2:  v = 64'sd274247419;
      3:  v = 64'sd134923406;
      4:  v = 64'sd67196451;
      5:  v = 64'sd33565361;
      6:  v = 64'sd16778582;
      7:  v = 64'sd8388779;
      8:  v = 64'sd4194325;
      9:  v = 64'sd2097155;
      default: begin
        if (i >= 10 && i <= 30) v = 64'sd1 <<< (30 - i);
      end
    endcase
    return v;
  endfunction

  function automatic logic [W-1:0] atanh_fix(input int i);
    longint r;
    r = (atanh_q30(i) + (64'sd1 <<< (29 - FRAC))) >>> (30 - FRAC);
    return r[W-1:0];
  endfunction

  logic [W-1:0] atanh_rom [0:31];

  for (genvar g = 0; g < 32; g++) begin : g_rom
    assign atanh_rom[g] = atanh_fix(g);
  end

  logic [1:0]          state;
  logic                md;
  logic [CW-1:0]       step;
  logic [4:0]          idx;
  logic                rep;
  logic signed [W-1:0] xr, yr, zr;
  logic signed [W-1:0] x_sh, y_sh, ang;
  logic signed [W-1:0] x_nx, y_nx, z_nx;
  logic                d_pos;
  logic                last;

  always_comb begin
    x_sh  = xr >>> idx;
    y_sh  = yr >>> idx;
    ang   = atanh_rom[idx];
    d_pos = md ? yr[W-1] : ~zr[W-1];
    if (d_pos) begin
      x_nx = xr + y_sh;
      y_nx = yr + x_sh;
      z_nx = zr - ang;
    end else begin
      x_nx = xr - y_sh;
      y_nx = yr - x_sh;
      z_nx = zr + ang;
    end
    last = (step == CW'(STEPS - 1));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      md    <= 1'b0;
      step  <= '0;
      idx   <= 5'd0;
      rep   <= 1'b0;
      xr    <= '0;
      yr    <= '0;
      zr    <= '0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xr    <= x_in;
            yr    <= y_in;
            zr    <= z_in;
            md    <= mode;
            step  <= '0;
            idx   <= 5'd1;
            rep   <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          xr   <= x_nx;
          yr   <= y_nx;
          zr   <= z_nx;
          step <= step + CW'(1);
          // Indices 4 and 13 run a second time before advancing.
          if ((idx == 5'd4 || idx == 5'd13) && !rep) begin
            rep <= 1'b1;
          end else begin
            idx <= idx + 5'd1;
            rep <= 1'b0;
          end
          if (last) state <= DONE;
        end
        DONE: begin
          x_out <= xr;
          y_out <= yr;
          z_out <= zr;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_hyperbolic_par.sv
// Bench for cordic_hyperbolic_par: default and wide instances checked against a
// real-arithmetic reference model plus the documented cosh/sinh/atanh scenarios.
module tb_cordic_hyperbolic_par;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic               start_d = 1'b0, mode_d = 1'b0;
  logic        [15:0] x_d = '0, y_d = '0, z_d = '0;
  logic               busy_d, done_d;
  logic signed [15:0] xo_d, yo_d, zo_d;

  logic               start_w = 1'b0, mode_w = 1'b0;
  logic        [23:0] x_w = '0, y_w = '0, z_w = '0;
  logic               busy_w, done_w;
  logic signed [23:0] xo_w, yo_w, zo_w;

  int n_vec = 0;
  int n_err = 0;

  cordic_hyperbolic_par dut (
    .clk(clk), .rst(rst), .start(start_d), .mode(mode_d),
    .x_in(x_d), .y_in(y_d), .z_in(z_d),
    .busy(busy_d), .done(done_d),
    .x_out(xo_d), .y_out(yo_d), .z_out(zo_d)
  );

  cordic_hyperbolic_par #(.W(24), .FRAC(20), .ITER(20)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .mode(mode_w),
    .x_in(x_w), .y_in(y_w), .z_in(z_w),
    .busy(busy_w), .done(done_w),
    .x_out(xo_w), .y_out(yo_w), .z_out(zo_w)
  );

  task automatic checkOutput(input string tag, input longint got, input longint exp,
                             input longint tol = 0);
    longint diff;
    n_vec++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic longint wrap(input longint v, input int w);
    longint t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  // Reference: index list with repeats, real-valued atanh quantised to Q2.30
  // and then to FRAC bits, w-bit wrapping arithmetic.
  function automatic void ref_model(input int w, input int frac, input int iter, input bit md,
                                    input longint xi, input longint yi, input longint zi,
                                    output longint xo, output longint yo, output longint zo);
    int     seq[$];
    longint x, y, z, xn, yn, zn, ang;
    real    t, a, q30;
    bit     d;
    for (int i = 1; i <= iter; i++) begin
      seq.push_back(i);
      if (i == 4 || i == 13) seq.push_back(i);
    end
    x = wrap(xi, w);
    y = wrap(yi, w);
    z = wrap(zi, w);
    foreach (seq[k]) begin
      int i;
      i   = seq[k];
      t   = 1.0 / (2.0 ** i);
      a   = 0.5 * $ln((1.0 + t) / (1.0 - t));
      q30 = $floor(a * 1073741824.0 + 0.5);
      ang = longint'($floor(q30 / (2.0 ** (30 - frac)) + 0.5));
      d   = md ? (y < 0) : (z >= 0);
      if (d) begin
        xn = x + (y >>> i);
        yn = y + (x >>> i);
        zn = z - ang;
      end else begin
        xn = x - (y >>> i);
        yn = y - (x >>> i);
        zn = z + ang;
      end
      x = wrap(xn, w);
      y = wrap(yn, w);
      z = wrap(zn, w);
    end
    xo = x;
    yo = y;
    zo = z;
  endfunction

  task automatic drive_ops(input bit wide, input bit md, input longint xi, input longint yi,
                           input longint zi, input bit st);
    if (wide) begin
      mode_w = md; x_w = xi[23:0]; y_w = yi[23:0]; z_w = zi[23:0]; start_w = st;
    end else begin
      mode_d = md; x_d = xi[15:0]; y_d = yi[15:0]; z_d = zi[15:0]; start_d = st;
    end
  endtask

  // Starts one operation and watches it; start is re-pulsed with scrambled
  // operands at edges re1/re2 (0 = never).
  task automatic applyStimulus(input bit wide, input bit md, input longint xi, input longint yi,
                               input longint zi, input int re1, input int re2,
                               output int done_edge, output int busy_cnt, output int done_cnt,
                               output bit moved, output longint xo, output longint yo,
                               output longint zo);
    longint px, py, pz, cx, cy, cz;
    bit     b, dn;
    @(negedge clk);
    drive_ops(wide, md, xi, yi, zi, 1'b1);
    @(posedge clk);
    #1;
    start_d = 1'b0;
    start_w = 1'b0;
    px = wide ? longint'(xo_w) : longint'(xo_d);
    py = wide ? longint'(yo_w) : longint'(yo_d);
    pz = wide ? longint'(zo_w) : longint'(zo_d);
    busy_cnt  = (wide ? busy_w : busy_d) ? 1 : 0;
    done_edge = -1;
    done_cnt  = 0;
    moved     = 1'b0;
    xo = 0; yo = 0; zo = 0;
    for (int e = 1; e <= 60; e++) begin
      if (e == re1 || e == re2)
        drive_ops(wide, ~md, longint'($urandom), longint'($urandom), longint'($urandom), 1'b1);
      @(posedge clk);
      #1;
      start_d = 1'b0;
      start_w = 1'b0;
      b  = wide ? busy_w : busy_d;
      dn = wide ? done_w : done_d;
      cx = wide ? longint'(xo_w) : longint'(xo_d);
      cy = wide ? longint'(yo_w) : longint'(yo_d);
      cz = wide ? longint'(zo_w) : longint'(zo_d);
      if (b) busy_cnt++;
      if (dn) done_cnt++;
      if (done_edge < 0) begin
        if (dn) begin
          done_edge = e;
          xo = cx; yo = cy; zo = cz;
        end else if (cx != px || cy != py || cz != pz) begin
          moved = 1'b1;
        end
      end else begin
        if (cx != xo || cy != yo || cz != zo) moved = 1'b1;
        if (e >= done_edge + 2) break;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input bit wide, input bit md, input longint xi,
                               input longint yi, input longint zi, input int re1, input int re2,
                               output longint xo, output longint yo, output longint zo);
    int     de, bc, dc, steps;
    bit     mv;
    longint ex, ey, ez;
    steps = wide ? 22 : 16;
    applyStimulus(wide, md, xi, yi, zi, re1, re2, de, bc, dc, mv, xo, yo, zo);
    if (wide) ref_model(24, 20, 20, md, xi, yi, zi, ex, ey, ez);
    else      ref_model(16, 12, 14, md, xi, yi, zi, ex, ey, ez);
    checkOutput({tag, ".x"}, xo, ex);
    checkOutput({tag, ".y"}, yo, ey);
    checkOutput({tag, ".z"}, zo, ez);
    checkOutput({tag, ".done_edge"}, de, steps + 1);
    checkOutput({tag, ".busy_cycles"}, bc, steps + 1);
    checkOutput({tag, ".done_pulses"}, dc, 1);
    checkOutput({tag, ".outputs_held"}, mv, 0);
  endtask

  initial begin
    longint xo, yo, zo, lim;
    int     dc;

    #12;
    checkOutput("reset.busy", busy_d, 0);
    checkOutput("reset.done", done_d, 0);
    checkOutput("reset.x", xo_d, 0);
    checkOutput("reset.y", yo_d, 0);
    checkOutput("reset.z", zo_d, 0);
    @(negedge clk);
    rst = 1'b0;

    run_and_check("cosh_pos", 0, 0, 4946, 0, 2048, 0, 0, xo, yo, zo);
    checkOutput("cosh_pos.cosh", xo, 4619, 4);
    checkOutput("cosh_pos.sinh", yo, 2134, 4);
    checkOutput("cosh_pos.zres", zo, 0, 4);

    run_and_check("cosh_neg", 0, 0, 4946, 0, -2048, 0, 0, xo, yo, zo);
    checkOutput("cosh_neg.cosh", xo, 4619, 4);
    checkOutput("cosh_neg.sinh", yo, -2134, 4);

    run_and_check("vector", 0, 1, 8192, 4096, 0, 0, 0, xo, yo, zo);
    checkOutput("vector.atanh", zo, 2250, 4);
    checkOutput("vector.mag", xo, 5875, 6);
    checkOutput("vector.yres", yo, 0, 4);

    for (int n = 0; n < 8; n++) begin
      run_and_check("rot_rand", 0, 0, longint'($urandom_range(1500, 8000)),
                    longint'($urandom_range(0, 4000)) - 2000,
                    longint'($urandom_range(0, 9000)) - 4500, 0, 0, xo, yo, zo);
    end
    for (int n = 0; n < 8; n++) begin
      xo  = longint'($urandom_range(2048, 8000));
      lim = (xo * 3) / 4;
      run_and_check("vec_rand", 0, 1, xo, longint'($urandom_range(0, 32'(2 * lim))) - lim,
                    longint'($urandom_range(0, 4000)) - 2000, 0, 0, xo, yo, zo);
    end

    run_and_check("repulse", 0, 0, 4946, 0, 2048, 3, 10, xo, yo, zo);
    checkOutput("repulse.cosh", xo, 4619, 4);

    // Abort an operation with reset at edge 8.
    @(negedge clk);
    drive_ops(0, 0, 4946, 0, 2048, 1'b1);
    @(posedge clk);
    #1;
    start_d = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid.busy", busy_d, 0);
    checkOutput("rst_mid.done", done_d, 0);
    checkOutput("rst_mid.x", xo_d, 0);
    checkOutput("rst_mid.y", yo_d, 0);
    checkOutput("rst_mid.z", zo_d, 0);
    @(negedge clk);
    rst = 1'b0;
    dc  = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done_d) dc++;
    end
    checkOutput("rst_mid.no_done", dc, 0);
    checkOutput("rst_mid.idle", busy_d, 0);
    run_and_check("after_rst", 0, 0, 4946, 0, 2048, 0, 0, xo, yo, zo);

    run_and_check("wide_cosh", 1, 0, 1266152, 0, 524288, 0, 0, xo, yo, zo);
    checkOutput("wide_cosh.cosh", xo,
                longint'($floor(($exp(0.5) + $exp(-0.5)) / 2.0 * 1048576.0 + 0.5)), 8);
    checkOutput("wide_cosh.sinh", yo,
                longint'($floor(($exp(0.5) - $exp(-0.5)) / 2.0 * 1048576.0 + 0.5)), 8);
    for (int n = 0; n < 3; n++) begin
      run_and_check("wide_rand", 1, 0, longint'($urandom_range(400000, 2000000)),
                    longint'($urandom_range(0, 1000000)) - 500000,
                    longint'($urandom_range(0, 2300000)) - 1150000, 0, 0, xo, yo, zo);
    end
    run_and_check("wide_vec", 1, 1, 2097152, 1048576, 0, 0, 0, xo, yo, zo);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_hyperbolic_par.md
CORDIC_HYPERBOLIC_PAR -- requirements
Module: cordic_hyperbolic_par

Interface
REQ-001 SHALL have parameter W, default 16, data word width in bits (range 12..32).
REQ-002 SHALL have parameter FRAC, default 12, fractional bits of the signed fixed-point format (FRAC <= W-3).
REQ-003 SHALL have parameter ITER, default 14, number of base iterations, indices i=1..ITER (range 4..30).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port start, input, 1, a one-cycle request to begin an operation.
REQ-007 SHALL have port mode, input, 1, operation select: 0 = rotation (sinh/cosh), 1 = vectoring (atanh, magnitude).
REQ-008 SHALL have ports x_in, y_in and z_in, each input, W bits, signed operands.
REQ-009 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse marking results valid.
REQ-011 SHALL have ports x_out, y_out and z_out, each output, W bits, signed registered results.

Function
REQ-012 SHALL have three FSM states: IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1, capture x_in, y_in, z_in and mode into working registers, reset the step counter, and move to RUN.
REQ-014 SHALL perform exactly one micro-rotation per clock in RUN.
REQ-015 SHALL execute the index sequence 1..ITER, with indices 4 and 13 each executed twice when they are <= ITER, giving STEPS = ITER + repeat count (16 for the defaults).
REQ-016 SHALL compute each micro-rotation as x' = x + d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atanh(2^-i), using an arithmetic right shift.
REQ-017 SHALL choose d in rotation mode as +1 when z >= 0, else -1.
REQ-018 SHALL choose d in vectoring mode as +1 when y < 0, else -1.
REQ-019 SHALL store the atanh table as Q2.30 constants for i=1..30 and rescale them to FRAC bits with round-half-up at elaboration; there SHALL be no runtime table writes.
REQ-020 SHALL use W-bit two's-complement arithmetic that wraps on overflow, with no saturation; keeping inputs inside the convergence range (|z| <= 1.118 in rotation, |y/x| <= 0.80 in vectoring) is the caller's responsibility.
REQ-021 SHALL move from RUN to DONE after the final step, then load x_out, y_out and z_out from the working registers and assert done for exactly one cycle.
REQ-022 SHALL return to IDLE one cycle after DONE.
REQ-023 SHALL place the done pulse on the edge STEPS+1 edges after the edge that sampled start (edge 17 for the defaults).
REQ-024 SHALL drive busy high in RUN and DONE and low in IDLE.
REQ-025 SHALL ignore start while busy=1, leaving the operation in flight and its operands unaffected.
REQ-026 SHALL accept start asserted in the same cycle that returns to IDLE on the next edge; back-to-back operations therefore have a throughput of one per STEPS+2 cycles.
REQ-027 SHALL hold x_out, y_out and z_out stable from done until the next done; outputs SHALL NOT change during RUN.
REQ-028 SHALL, in rotation mode with x_in = 1/Kh and y_in = 0, return x_out = cosh(z_in) and y_out = sinh(z_in), where Kh is the hyperbolic gain (about 0.8282 for the defaults).
REQ-029 SHALL, in vectoring mode, return x_out = Kh*sqrt(x_in^2 - y_in^2) and z_out = z_in + atanh(y_in/x_in), with y_out near 0.

Reset
REQ-030 SHALL, while rst=1, immediately force the FSM to IDLE, set busy=0 and done=0, and clear x_out, y_out, z_out, the working registers and the step counter to 0.
REQ-031 SHALL, when rst asserts mid-operation, abandon the operation without a done pulse; the first start after rst deasserts SHALL begin a fresh operation.

Verification
REQ-032 SHALL cover this scenario: defaults, mode=0, x_in=4946 (1/Kh), y_in=0, z_in=2048 (0.5) -> done at edge 17, x_out=4619 +/-4, y_out=2134 +/-4, z_out within +/-4 of 0.
REQ-033 SHALL cover this scenario: defaults, mode=0, z_in=-2048, x and y as in REQ-032 -> x_out=4619 +/-4, y_out=-2134 +/-4.
REQ-034 SHALL cover this scenario: defaults, mode=1, x_in=8192 (2.0), y_in=4096 (1.0), z_in=0 -> z_out=2250 +/-4, x_out=5875 +/-6, |y_out| <= 4.
REQ-035 SHALL cover this scenario: start re-pulsed at edges 3 and 10 of a running operation -> results identical to a single start, exactly one done, busy continuous for 17 cycles.
REQ-036 SHALL cover this scenario: rst pulsed at edge 8 of an operation -> busy=0 and all outputs 0 immediately, no done; a new start then completes normally at edge 17.
REQ-037 SHALL cover this scenario: a parameter sweep with W=24, FRAC=20, ITER=20 running REQ-032 rescaled -> cosh and sinh within +/-8 LSB, done at edge 23 (20 + 2 repeats + 1).
